// File: rtl/instr_fetch_queue_pkg.sv
// Shared definitions for the fetch queue and the execute stage:
// opcode constants, instruction field positions, queue entry layout
// and the opcode legality check.
package instr_fetch_queue_pkg;

    localparam logic [7:0] OP_ADD = 8'h01;
    localparam logic [7:0] OP_MUL = 8'h02;
    localparam logic [7:0] OP_CLR = 8'h03;

    localparam int OPC_LSB = 0;
    localparam int OPC_W   = 8;
    localparam int IMM_LSB = 8;
    localparam int IMM_W   = 24;

    localparam int ENTRY_W = 64;

    // One queued instruction: the word and the unwrapped PC it came from.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fq_entry_t;

    function automatic logic is_legal_op(input logic [7:0] op);
        return (op == OP_ADD) || (op == OP_MUL) || (op == OP_CLR);
    endfunction

endpackage

// File: rtl/instr_fetch_queue_fifo.sv
// fetch_fifo: DEPTH x W synchronous FIFO with flush, occupancy count and
// full/empty flags. Head is read straight from storage (registered data).
// Callers are responsible for not pushing when full or popping when empty.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_flush,
    input  logic          i_push,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_pop,
    output logic [W-1:0]  o_rdata,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Storage, pointers and count; flush drops everything but keeps stale data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (i_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: sequential instruction fetch with credit-based issue
// into a small prefetch FIFO, valid/ready output, opcode predecode and
// redirect/flush. Optional feature macro FETCH_BYPASS_EN lets a response
// arriving at an empty queue drive the outputs in the same cycle.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          AW       = 5,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fetch_en,
    output logic          imem_en,
    output logic [AW-1:0] imem_addr,
    input  logic [31:0]   imem_rdata,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_instr,
    output logic [31:0]   out_pc,
    output logic          out_illegal
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_inflight_pc;
    logic          r_inflight;

    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_empty;
    logic [CW:0]   w_credit;
    logic          w_issue;
    logic          w_resp;
    logic          w_bypass;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    fq_entry_t     w_resp_entry;
    fq_entry_t     w_head;
    fq_entry_t     w_out;
    logic [ENTRY_W-1:0] w_head_raw;

    // Outstanding slots = queued + in flight, using pre-pop count so the
    // FIFO can never be overrun even if the head is not accepted.
    assign w_credit = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
    assign w_issue  = fetch_en & ~redirect_valid & ~rst & (w_credit < (CW+1)'(DEPTH));

    // A response landing during a redirect belongs to the old stream.
    assign w_resp       = r_inflight & ~redirect_valid;
    assign w_resp_entry = '{instr: imem_rdata, pc: r_inflight_pc};

`ifdef FETCH_BYPASS_EN
    assign w_bypass = w_empty & w_resp;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_head    = fq_entry_t'(w_head_raw);
    assign w_out     = w_bypass ? w_resp_entry : w_head;
    assign out_valid = ~redirect_valid & (~w_empty | w_bypass);
    assign w_accept  = out_valid & out_ready;

    // A bypassed response that is taken immediately never enters the FIFO.
    assign w_push = w_resp & ~w_full & ~(w_bypass & out_ready);
    assign w_pop  = w_accept & ~w_empty;

    // Fetch PC and single outstanding request tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc <= redirect_pc;
            r_inflight <= 1'b0;
        end else if (w_issue) begin
            r_inflight    <= 1'b1;
            r_inflight_pc <= r_fetch_pc;
            r_fetch_pc    <= r_fetch_pc + 32'd1;
        end else begin
            r_inflight <= 1'b0;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (redirect_valid),
        .i_push  (w_push),
        .i_wdata (w_resp_entry),
        .i_pop   (w_pop),
        .o_rdata (w_head_raw),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign imem_en     = w_issue;
    assign imem_addr   = r_fetch_pc[AW-1:0];
    assign out_instr   = w_out.instr;
    assign out_pc      = w_out.pc;
    assign out_illegal = ~is_legal_op(w_out.instr[OPC_LSB +: OPC_W]);

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: a memory model answers reads one
// cycle late; every issued request pushes its expected {instr, pc} and every
// accepted output is popped and compared. A second instance with
// RESET_PC=30 exercises address wrap.
module tb_instr_fetch_queue;

    localparam int AW = 5;
`ifdef FETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic          clk;
    logic          rst;
    logic          fetch_en;
    logic          imem_en, imem_en2;
    logic [AW-1:0] imem_addr, imem_addr2;
    logic [31:0]   rdata, rdata2;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          out_valid, out_valid2;
    logic          out_ready;
    logic [31:0]   out_instr, out_instr2;
    logic [31:0]   out_pc, out_pc2;
    logic          out_illegal, out_illegal2;

    logic [31:0] mem [32];
    logic [63:0] sb[$];
    logic [63:0] sb2[$];
    logic [63:0] e;
    logic [31:0] exp_pc, exp_pc2, redir_pc_exp;
    int n_chk = 0, n_pass = 0;
    int cyc = 0, first_iss = -1, first_ov = -1, redir_cyc = -1;
    int n_ill = 0, n_pop2 = 0;
    logic want_redir = 1'b0;
    logic found;

    instr_fetch_queue #(.DEPTH(4), .AW(AW), .RESET_PC(32'd0)) u_dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .imem_en(imem_en),
        .imem_addr(imem_addr), .imem_rdata(rdata), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .out_illegal(out_illegal)
    );

    instr_fetch_queue #(.DEPTH(4), .AW(AW), .RESET_PC(32'd30)) u_dut_rpc (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .imem_en(imem_en2),
        .imem_addr(imem_addr2), .imem_rdata(rdata2), .redirect_valid(1'b0),
        .redirect_pc(32'd0), .out_valid(out_valid2), .out_ready(1'b1),
        .out_instr(out_instr2), .out_pc(out_pc2), .out_illegal(out_illegal2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // one-cycle-latency instruction memory for both instances
    always @(posedge clk) begin
        if (imem_en)  rdata  <= mem[imem_addr];
        if (imem_en2) rdata2 <= mem[imem_addr2];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic ill_of(input logic [31:0] w);
        return !(w[7:0] == 8'h01 || w[7:0] == 8'h02 || w[7:0] == 8'h03);
    endfunction

    // monitor: build expectations on issue, compare on acceptance
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            sb.delete(); sb2.delete();
            exp_pc = 32'd0; exp_pc2 = 32'd30;
            first_iss = -1; first_ov = -1;
        end else begin
            if (redirect_valid) begin
                chk("redir_ov0", 64'(out_valid), 64'd0);
                sb.delete();
                exp_pc = redirect_pc; redir_pc_exp = redirect_pc;
                redir_cyc = cyc; want_redir = 1'b1;
            end
            if (imem_en) begin
                chk("iss_addr", 64'(imem_addr), 64'(exp_pc[AW-1:0]));
                if (first_iss < 0) first_iss = cyc;
                sb.push_back({mem[exp_pc[AW-1:0]], exp_pc});
                exp_pc = exp_pc + 32'd1;
            end
            if (out_valid && first_ov < 0) first_ov = cyc;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
                else begin
                    e = sb.pop_front();
                    chk("out_pc", 64'(out_pc), 64'(e[31:0]));
                    chk("out_instr", 64'(out_instr), 64'(e[63:32]));
                    chk("out_ill", 64'(out_illegal), 64'(ill_of(e[63:32])));
                    if (ill_of(e[63:32]) && out_illegal) n_ill++;
                end
                if (want_redir) begin
                    want_redir = 1'b0;
                    chk("redir_pc", 64'(out_pc), 64'(redir_pc_exp));
                    chk("redir_lat", 64'(cyc - redir_cyc), 64'(LAT + 1));
                end
            end
            if (imem_en2) begin
                chk("iss_addr2", 64'(imem_addr2), 64'(exp_pc2[AW-1:0]));
                sb2.push_back({mem[exp_pc2[AW-1:0]], exp_pc2});
                exp_pc2 = exp_pc2 + 32'd1;
            end
            if (out_valid2) begin
                if (sb2.size() == 0) chk("sb2_underflow", 64'd1, 64'd0);
                else begin
                    e = sb2.pop_front();
                    chk("out_pc2", 64'(out_pc2), 64'(e[31:0]));
                    chk("out_instr2", 64'(out_instr2), 64'(e[63:32]));
                    n_pop2++;
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = {24'(i), 8'h01};
        mem[24] = {24'd24, 8'h00};
        mem[25] = {24'd25, 8'h07};
        mem[26] = {24'd26, 8'h03};
        rst = 1'b1; fetch_en = 1'b1; out_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 32'd0;

        // reset state, with fetch_en already high
        repeat (3) @(negedge clk);
        chk("rst_ov", 64'(out_valid), 64'd0);
        chk("rst_en", 64'(imem_en), 64'd0);
        chk("rst_instr", 64'(out_instr), 64'd0);
        chk("rst_pc", 64'(out_pc), 64'd0);
        chk("rst_en2", 64'(imem_en2), 64'd0);
        chk("rst_addr2", 64'(imem_addr2), 64'd30);
        @(posedge clk); #1 rst = 1'b0;

        // streaming: latency and one-per-cycle throughput
        repeat (6) @(negedge clk);
        chk("latency", 64'(first_ov - first_iss), 64'(LAT));
        repeat (16) begin
            @(negedge clk);
            chk("thru", 64'(out_valid), 64'd1);
        end

        // back-pressure: exactly DEPTH held, fetch stops
        @(posedge clk); #1 out_ready = 1'b0;
        repeat (10) @(negedge clk);
        chk("bp_held", 64'(sb.size()), 64'd4);
        chk("bp_imem_en", 64'(imem_en), 64'd0);
        chk("bp_ov", 64'(out_valid), 64'd1);
        @(posedge clk); #1 out_ready = 1'b1;
        repeat (12) @(negedge clk);

        // reset mid-stream with a full queue
        @(posedge clk); #1 out_ready = 1'b0;
        repeat (8) @(negedge clk);
        chk("full_held", 64'(sb.size()), 64'd4);
        @(posedge clk); #1 rst = 1'b1;
        #1;
        chk("rst_ov_drop", 64'(out_valid), 64'd0);
        chk("rst_en_drop", 64'(imem_en), 64'd0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;

        // redirect to 20 while PC 7 is in flight
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (imem_en && imem_addr == 5'd7) found = 1'b1;
        end
        chk("saw_pc7", 64'(found), 64'd1);
        @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'd20;
        @(posedge clk); #1 redirect_valid = 1'b0;
        repeat (20) @(negedge clk);
        chk("redir_seen", 64'(want_redir), 64'd0);

        // fetch disabled: everything drains, no new requests
        @(posedge clk); #1 fetch_en = 1'b0;
        repeat (6) @(negedge clk);
        chk("drain_en", 64'(imem_en), 64'd0);
        chk("drain_empty", 64'(sb.size()), 64'd0);
        chk("drain_ov", 64'(out_valid), 64'd0);
        chk("ill_seen", 64'(n_ill >= 2), 64'd1);
        chk("rpc_pops", 64'(n_pop2 >= 3), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
